// File: rtl/bfp_comp_exp_stream.sv
// Block-floating-point compressor: one shared exponent per block,
// rounded/saturated mantissas, valid/ready on both sides.
module bfp_comp_exp_stream #(
  parameter int LANES      = 4,
  parameter int SAMPLE_W   = 16,
  parameter int BEATS      = 6,
  parameter int EXP_W      = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LANES*SAMPLE_W-1:0]     din_data,
  input  logic                          din_valid,
  input  logic                          din_last,
  output logic                          din_ready,
  output logic [LANES*SAMPLE_W-1:0]     dout_data,
  output logic [EXP_W-1:0]              dout_exp,
  output logic                          dout_first,
  output logic                          dout_last,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  input  logic [$clog2(SAMPLE_W+1)-1:0] ud_iq_width,
  input  logic                          sat_clear,
  output logic [15:0]                   sat_count
);

  localparam int DW = LANES * SAMPLE_W;
  localparam int WW = $clog2(SAMPLE_W + 1);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(LANES + 1);
  localparam int EW = DW + 3;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] max_q, max_d;
  logic [WW-1:0]       w_q, w_d;
  logic [SAMPLE_W-1:0] smp, mag;
  logic [WW-1:0]       nbits;
  logic [EXP_W-1:0]    exp_new;
  logic                accept, close, byp_in;

  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wp_q, rp_q;
  logic [NW-1:0]       fcnt_q;
  logic [EW-1:0]       head;

  logic [EXP_W-1:0]    eq_exp_q [2];
  logic [WW-1:0]       eq_w_q [2];
  logic                eq_wp_q, eq_rp_q;
  logic [1:0]          ecnt_q;
  logic                pop, eq_pop, eq_push;

  logic                s1_vld_q, s1_first_q, s1_last_q;
  logic [DW-1:0]       s1_data_q;
  logic [EXP_W-1:0]    s1_exp_q;
  logic [WW-1:0]       s1_w_q;
  logic                s1_rdy, out_rdy, load;

  logic                vld_q, first_q, last_q;
  logic [DW-1:0]       data_q;
  logic [EXP_W-1:0]    exp_q;
  logic [15:0]         sat_q;
  logic [16:0]         sat_sum;

  logic signed [SAMPLE_W:0] xs, rnd, sum, q, hi, lo;
  logic [DW-1:0]       mant;
  logic [SW-1:0]       nsat;
  logic                byp_out;

  assign din_ready = !rst && (fcnt_q != NW'(FIFO_DEPTH)) && (ecnt_q != 2'd2);
  assign accept    = din_valid && din_ready;

  // Running max merges the current beat so the closing beat can push its exponent
  always_comb begin
    smp   = '0;
    mag   = '0;
    max_d = (cnt_q == '0) ? '0 : max_q;
    w_d   = (cnt_q == '0) ? ud_iq_width : w_q;
    for (int l = 0; l < LANES; l++) begin
      smp = din_data[DW-1-l*SAMPLE_W -: SAMPLE_W];
      mag = smp[SAMPLE_W-1] ? ~smp : smp;
      if (mag > max_d) max_d = mag;
    end
    nbits = WW'(1);
    for (int i = 0; i < SAMPLE_W; i++)
      if (max_d[i]) nbits = WW'(i + 2);
    byp_in  = (w_d == '0) || (w_d >= WW'(SAMPLE_W));
    exp_new = '0;
    if (!byp_in && nbits > w_d) exp_new = EXP_W'(nbits - w_d);
    close = din_last || (cnt_q == CW'(BEATS - 1));
    cnt_d = cnt_q;
    if (accept) cnt_d = close ? '0 : cnt_q + 1'b1;
  end

  assign head    = mem_q[rp_q];
  assign out_rdy = !vld_q || dout_ready;
  assign s1_rdy  = !s1_vld_q || out_rdy;
  assign pop     = (fcnt_q != '0) && (ecnt_q != '0) && s1_rdy;
  assign eq_pop  = pop && head[EW-3];
  assign eq_push = accept && close;
  assign load    = out_rdy && s1_vld_q;

  always_comb begin
    mant    = '0;
    nsat    = '0;
    xs      = '0;
    sum     = '0;
    q       = '0;
    byp_out = (s1_w_q == '0) || (s1_w_q >= WW'(SAMPLE_W));
    hi      = ((SAMPLE_W+1)'(1) << (s1_w_q - 1'b1)) - 1'b1;
    lo      = ~hi;
    rnd     = '0;
    if (s1_exp_q != '0) rnd = (SAMPLE_W+1)'(1) << (s1_exp_q - 1'b1);
    for (int l = 0; l < LANES; l++) begin
      xs  = {s1_data_q[DW-1-l*SAMPLE_W], s1_data_q[DW-1-l*SAMPLE_W -: SAMPLE_W]};
      sum = xs + rnd;
      q   = sum >>> s1_exp_q;
      if (byp_out) begin
        mant[DW-1-l*SAMPLE_W -: SAMPLE_W] = s1_data_q[DW-1-l*SAMPLE_W -: SAMPLE_W];
      end else if (q > hi) begin
        mant[DW-1-l*SAMPLE_W -: SAMPLE_W] = hi[SAMPLE_W-1:0];
        nsat = nsat + 1'b1;
      end else if (q < lo) begin
        mant[DW-1-l*SAMPLE_W -: SAMPLE_W] = lo[SAMPLE_W-1:0];
        nsat = nsat + 1'b1;
      end else begin
        mant[DW-1-l*SAMPLE_W -: SAMPLE_W] = q[SAMPLE_W-1:0];
      end
    end
    sat_sum = {1'b0, sat_q} + 17'(nsat);
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wp_q] <= {cnt_q == '0, din_last, close, din_data};
    if (eq_push) begin
      eq_exp_q[eq_wp_q] <= exp_new;
      eq_w_q[eq_wp_q]   <= w_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      max_q      <= '0;
      w_q        <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      fcnt_q     <= '0;
      eq_wp_q    <= 1'b0;
      eq_rp_q    <= 1'b0;
      ecnt_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_exp_q   <= '0;
      s1_w_q     <= '0;
      vld_q      <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      exp_q      <= '0;
      sat_q      <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        max_q <= max_d;
        w_q   <= w_d;
        wp_q  <= nxt(wp_q);
      end
      if (pop) rp_q <= nxt(rp_q);
      fcnt_q <= fcnt_q + NW'(accept) - NW'(pop);
      if (eq_push) eq_wp_q <= ~eq_wp_q;
      if (eq_pop) eq_rp_q <= ~eq_rp_q;
      ecnt_q <= ecnt_q + 2'(eq_push) - 2'(eq_pop);
      if (s1_rdy) s1_vld_q <= pop;
      if (pop) begin
        s1_data_q  <= head[DW-1:0];
        s1_first_q <= head[EW-1];
        s1_last_q  <= head[EW-2];
        s1_exp_q   <= eq_exp_q[eq_rp_q];
        s1_w_q     <= eq_w_q[eq_rp_q];
      end
      if (out_rdy) vld_q <= s1_vld_q;
      if (load) begin
        data_q  <= mant;
        exp_q   <= s1_exp_q;
        first_q <= s1_first_q;
        last_q  <= s1_last_q;
      end
      if (sat_clear) sat_q <= '0;
      else if (load) sat_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  assign dout_valid = vld_q;
  assign dout_data  = data_q;
  assign dout_exp   = exp_q;
  assign dout_first = first_q;
  assign dout_last  = last_q;
  assign sat_count  = sat_q;

endmodule

// File: tb/tb_bfp_comp_exp_stream.sv
// Randomised bench for bfp_comp_exp_stream against an arithmetic
// block model; directed cases for latency, saturation, bypass, reset.
module tb_bfp_comp_exp_stream;

  localparam int L  = 4;
  localparam int SW = 16;
  localparam int B  = 6;
  localparam int EW = 4;
  localparam int DW = L * SW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din_data = '0;
  logic          din_valid = 1'b0;
  logic          din_last = 1'b0;
  logic          din_ready;
  logic [DW-1:0] dout_data;
  logic [EW-1:0] dout_exp;
  logic          dout_first, dout_last, dout_valid;
  logic          dout_ready = 1'b1;
  logic [4:0]    ud_iq_width = 5'd8;
  logic          sat_clear = 1'b0;
  logic [15:0]   sat_count;

  int errors = 0, checks = 0, cyc = 0;
  int sat_exp = 0, pushed = 0, popped = 0, close_cyc = 0;
  bit rnd_rdy = 1'b0;

  logic [15:0] blk [B][L];

  typedef struct {
    logic [DW-1:0] d;
    logic [EW-1:0] e;
    bit            f;
    bit            l;
    int            s;
  } beat_t;
  beat_t expq [$];

  bfp_comp_exp_stream dut (
    .clk(clk), .rst(rst),
    .din_data(din_data), .din_valid(din_valid),
    .din_last(din_last), .din_ready(din_ready),
    .dout_data(dout_data), .dout_exp(dout_exp),
    .dout_first(dout_first), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .ud_iq_width(ud_iq_width), .sat_clear(sat_clear),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Peek every valid beat so stalled outputs must stay equal to the model
  always @(negedge clk) begin
    dout_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!rst && dout_valid) begin
      if (expq.size() == 0) begin
        chk("spurious", 1, 0);
      end else begin
        chk("beat", {dout_first, dout_last, dout_exp, dout_data},
            {expq[0].f, expq[0].l, expq[0].e, expq[0].d});
        if (dout_ready) begin
          sat_exp = (sat_exp + expq[0].s > 65535) ? 65535 : sat_exp + expq[0].s;
          void'(expq.pop_front());
          popped++;
        end
      end
    end
  end

  function automatic logic [15:0] rs();
    logic signed [15:0] t;
    int k;
    k = $urandom_range(0, 9);
    t = 16'($urandom);
    if (k == 0) return 16'h7FFF;
    if (k == 1) return 16'h8000;
    return t >>> $urandom_range(0, 14);
  endfunction

  task automatic fill_zero();
    for (int b = 0; b < B; b++)
      for (int l = 0; l < L; l++) blk[b][l] = '0;
  endtask

  task automatic fill_rand();
    for (int b = 0; b < B; b++)
      for (int l = 0; l < L; l++) blk[b][l] = rs();
  endtask

  task automatic model_block(input int n, input bit lastf, input int w);
    int mx, nb, e;
    bit byp;
    mx  = 0;
    nb  = 1;
    byp = (w == 0) || (w >= SW);
    for (int b = 0; b < n; b++)
      for (int l = 0; l < L; l++) begin
        int x, m;
        x = $signed(blk[b][l]);
        m = (x < 0) ? -x - 1 : x;
        if (m > mx) mx = m;
      end
    while (mx >= (1 << (nb - 1))) nb++;
    e = (byp || nb <= w) ? 0 : nb - w;
    for (int b = 0; b < n; b++) begin
      beat_t t;
      t.d = '0;
      t.s = 0;
      t.e = EW'(e);
      t.f = (b == 0);
      t.l = lastf && (b == n - 1);
      for (int l = 0; l < L; l++) begin
        int x, q;
        x = $signed(blk[b][l]);
        if (byp) begin
          q = x;
        end else begin
          q = (x + ((e > 0) ? (1 << (e - 1)) : 0)) >>> e;
          if (q > (1 << (w - 1)) - 1) begin
            q = (1 << (w - 1)) - 1;
            t.s++;
          end else if (q < -(1 << (w - 1))) begin
            q = -(1 << (w - 1));
            t.s++;
          end
        end
        t.d[DW-1-SW*l -: SW] = q[15:0];
      end
      expq.push_back(t);
      pushed++;
    end
  endtask

  task automatic send_beat(input int b, input bit lst, input int w);
    int g;
    g = 0;
    @(negedge clk);
    for (int l = 0; l < L; l++) din_data[DW-1-SW*l -: SW] = blk[b][l];
    din_valid   = 1'b1;
    din_last    = lst;
    ud_iq_width = 5'(w);
    while (!din_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) chk("in_timeout", 1, 0);
    close_cyc = cyc;
  endtask

  task automatic send_block(input int n, input bit lastf,
                            input int w, input int wmid);
    model_block(n, lastf, w);
    for (int b = 0; b < n; b++)
      send_beat(b, lastf && (b == n - 1), (b == 0) ? w : wmid);
  endtask

  task automatic drain();
    int g;
    g = 0;
    @(negedge clk);
    din_valid = 1'b0;
    din_last  = 1'b0;
    while (expq.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (expq.size() != 0) chk("drain_timeout", expq.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int got, t0, n;
    bit lf;
    repeat (3) @(negedge clk);
    chk("rst_valid", dout_valid, 0);
    chk("rst_flags", {dout_first, dout_last}, 0);
    chk("rst_exp", dout_exp, 0);
    chk("rst_data", dout_data, 0);
    chk("rst_sat", sat_count, 0);
    chk("rst_ready", din_ready, 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", din_ready, 1);

    fill_zero();
    blk[0][0] = 16'h1234;
    send_block(6, 1'b0, 8, 8);
    t0  = close_cyc;
    got = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      din_valid = 1'b0;
      if (dout_valid) begin
        got = cyc - t0;
        break;
      end
    end
    chk("latency", got, 3);
    chk("t1_exp", dout_exp, 6);
    chk("t1_lane0", dout_data[DW-1 -: SW], 16'h0049);
    chk("t1_first", dout_first, 1);
    drain();

    @(negedge clk) sat_clear = 1'b1;
    @(negedge clk) sat_clear = 1'b0;
    sat_exp = 0;
    chk("sat_clear", sat_count, 0);
    fill_zero();
    blk[0][0] = 16'h7FFF;
    blk[0][1] = 16'h8000;
    send_block(6, 1'b0, 8, 8);
    drain();
    chk("t2_sat", sat_count, 1);

    fill_zero();
    send_block(6, 1'b0, 8, 8);
    fill_rand();
    send_block(6, 1'b0, 0, 0);
    fill_rand();
    send_block(4, 1'b1, 16, 16);
    fill_rand();
    send_block(3, 1'b1, 10, 10);
    fill_rand();
    send_block(6, 1'b0, 10, 10);
    fill_rand();
    send_block(1, 1'b1, 6, 6);
    fill_rand();
    send_block(6, 1'b0, 8, 12);
    fill_rand();
    send_block(6, 1'b1, 12, 12);
    drain();

    rnd_rdy = 1'b1;
    repeat (100) begin
      fill_rand();
      n  = $urandom_range(1, B);
      lf = (n < B) ? 1'b1 : 1'($urandom_range(0, 1));
      send_block(n, lf, $urandom_range(0, 16), $urandom_range(0, 16));
    end
    drain();
    rnd_rdy = 1'b0;
    chk("sat_run", sat_count, sat_exp);

    fill_rand();
    send_beat(0, 1'b0, 8);
    send_beat(1, 1'b0, 8);
    send_beat(2, 1'b0, 8);
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b0;
    #1 chk("rst_mid_ready", din_ready, 0);
    repeat (2) @(negedge clk);
    chk("rst_mid_valid", dout_valid, 0);
    chk("rst_mid_sat", sat_count, 0);
    chk("rst_mid_out", {dout_exp, dout_data}, 0);
    rst     = 1'b0;
    sat_exp = 0;
    fill_rand();
    send_block(6, 1'b0, 9, 9);
    fill_rand();
    send_block(2, 1'b1, 5, 5);
    drain();

    chk("beat_count", popped, pushed);
    chk("sat_end", sat_count, sat_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
